feistel_round_seq: RTL and testbench
====================================

# feistel_round_seq

Parametrised Feistel round sequencer: the L/R datapath and round control for the block-cipher cores. It accepts one block through a valid/ready handshake and iterates `ROUNDS` Feistel rounds using an external round function `f_out`. It drives the round index to the key schedule in encrypt or decrypt order and returns the final-swapped block through a valid/ready handshake. It sits between the input permutation and the output permutation, alongside the f-function and the key schedule.

## Interface
Parameters:
- `HALF_W`, 32: width of each half (L, R); the block is 2*HALF_W bits.
- `ROUNDS`, 16: number of Feistel rounds; legal range 1..(2^CNT_W - 1).
- `CNT_W`, 5: width of the round counter and `round_idx`.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  input block valid.
- `in_ready`  out  1  block can be accepted; high only in IDLE.
- `decrypt`  in  1  mode; sampled with the accepted block.
- `L_init`  in  HALF_W  left half of the input block.
- `R_init`  in  HALF_W  right half of the input block.
- `f_out`  in  HALF_W  f(R_dat, subkey[round_idx]); combinational from the outside, used in the same cycle.
- `L_dat`  out  HALF_W  current left register.
- `R_dat`  out  HALF_W  current right register; feeds the f-function.
- `round_idx`  out  CNT_W  subkey index for the current round.
- `round_en`  out  1  high while a round executes (RUN).
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts the result.
- `blk_out`  out  2*HALF_W  {R_dat, L_dat}, the final swap.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`: `L_dat`<=`L_init`, `R_dat`<=`R_init`, `cnt`<=0, `mode`<=`decrypt`, go to RUN.
- **RUN**
  - Each cycle: `R_dat`<=`L_dat ^ f_out`, `L_dat`<=`R_dat`, `cnt`<=`cnt`+1.
  - When `cnt`==ROUNDS-1, that last round executes and the state goes to DONE.
- **round_idx**
  - Equals `cnt` when `mode`=0 and ROUNDS-1-`cnt` when `mode`=1.
  - Valid in RUN; 0 in IDLE and DONE.
- **DONE**
  - `out_valid`=1; `L_dat`, `R_dat` and `blk_out` hold.
  - On `out_ready`, go to IDLE.
- `in_valid` outside IDLE is ignored; no queueing.
- `decrypt` changes after acceptance have no effect on the block in flight.
- `blk_out` is `{R_dat, L_dat}` at all times. It is meaningful only while `out_valid`=1.
- **Reset**
  - Any cycle with `rst`=1, including mid-RUN or DONE, forces IDLE, `cnt`=0, `mode`=0, `L_dat`=`R_dat`=0.
  - Outputs after reset: `out_valid`=0, `round_en`=0, `round_idx`=0, `in_ready`=1, `blk_out`=0.
  - A block in flight is discarded; no `out_valid` is produced for it.
- **Widths**
  - XOR is bitwise over HALF_W; no carries.
  - `cnt` never exceeds ROUNDS-1 and does not wrap.

## Timing
- Acceptance edge is A (`in_valid` && `in_ready`).
- Round k (k=0..ROUNDS-1) executes in the cycle after edge A+k. It updates the registers at edge A+k+1.
- `out_valid` rises after edge A+ROUNDS. Acceptance-to-result latency is ROUNDS cycles.
- The `out_valid` && `out_ready` edge returns to IDLE. The next block can be accepted on the following edge.
- Minimum issue interval is ROUNDS+2 cycles with `out_ready` tied high.
- `out_valid` stays high and `blk_out` stable until `out_ready`, with no limit on stall length.
- `round_en` is high for exactly ROUNDS consecutive cycles per block.
- `in_ready` and `out_valid` are never high in the same cycle.

## Test plan
- **Encrypt, even rounds, identity f:** ROUNDS=16, `f_out`=0, L=0x01234567, R=0x89ABCDEF, `decrypt`=0 -> `out_valid` exactly 16 cycles after acceptance; `blk_out`=0x89ABCDEF_01234567; `round_idx` runs 0..15.
- **Decrypt order:** same block with `decrypt`=1 and the bench f = R ^ K[idx] with K[i]=0x11111111*i -> `round_idx` runs 15..0. Re-feeding the swapped encrypt output in decrypt mode recovers L=0x01234567, R=0x89ABCDEF.
- **Odd rounds:** ROUNDS=3, HALF_W=16, `f_out`=0, L=0x1234, R=0xABCD -> `blk_out`=0x1234ABCD after 3 cycles.
- **Backpressure:** `out_ready`=0 for 10 cycles in DONE -> `blk_out` stable, `in_ready`=0, and an `in_valid` pulse is ignored. Raising `out_ready` -> IDLE on the next edge, then the next block is accepted.
- **Reset mid-RUN:** `rst`=1 at round 7 -> next cycle has IDLE, `L_dat`=`R_dat`=0, `round_en`=0, `in_ready`=1, and no `out_valid`. A fresh block afterwards completes correctly.
- **Back-to-back:** continuous `in_valid`, `out_ready`=1 -> blocks accepted every ROUNDS+2 cycles; each result is correct; mode is taken per block.

Source files
------------

// File: rtl/feistel_round_seq.sv
// feistel_round_seq: L/R datapath and round sequencing for an iterated Feistel cipher core.
module feistel_round_seq #(
    parameter int HALF_W = 32,
    parameter int ROUNDS = 16,
    parameter int CNT_W  = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                decrypt,
    input  logic [HALF_W-1:0]   L_init,
    input  logic [HALF_W-1:0]   R_init,
    input  logic [HALF_W-1:0]   f_out,
    output logic [HALF_W-1:0]   L_dat,
    output logic [HALF_W-1:0]   R_dat,
    output logic [CNT_W-1:0]    round_idx,
    output logic                round_en,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*HALF_W-1:0] blk_out
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ROUNDS - 1);
    state_t             r_state, w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_mode;
    logic [HALF_W-1:0]  r_l, r_r;
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = in_valid ? RUN : IDLE;
            RUN:     w_next = (r_cnt == LAST) ? DONE : RUN;
            DONE:    w_next = out_ready ? IDLE : DONE;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_mode  <= 1'b0;
            r_l     <= '0;
            r_r     <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && in_valid) begin
                r_l    <= L_init;
                r_r    <= R_init;
                r_cnt  <= '0;
                r_mode <= decrypt;
            end else if (r_state == RUN) begin
                r_l   <= r_r;
                r_r   <= r_l ^ f_out;
                // Saturate on the last round so the counter never leaves 0..ROUNDS-1
                r_cnt <= (r_cnt == LAST) ? r_cnt : r_cnt + 1'b1;
            end
        end
    end
    assign in_ready  = (r_state == IDLE);
    assign round_en  = (r_state == RUN);
    assign out_valid = (r_state == DONE);
    assign round_idx = round_en ? (r_mode ? LAST - r_cnt : r_cnt) : '0;
    assign L_dat     = r_l;
    assign R_dat     = r_r;
    assign blk_out   = {r_r, r_l};
endmodule

// File: tb/tb_feistel_round_seq.sv
// tb_feistel_round_seq: directed and randomized checks of the Feistel sequencer against a round-by-round model.
module tb_feistel_round_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, decrypt = 1'b0, out_ready = 1'b1, fsel = 1'b0;
    logic [31:0] L_init = '0, R_init = '0, f_out, L_dat, R_dat;
    logic [4:0]  round_idx;
    logic        in_ready, round_en, out_valid;
    logic [63:0] blk_out;
    logic        s_in_valid = 1'b0, s_dec = 1'b0, s_in_ready, s_round_en, s_out_valid;
    logic [15:0] s_L = '0, s_R = '0, s_L_dat, s_R_dat;
    logic [1:0]  s_round_idx;
    logic [31:0] s_blk;
    int          vectors = 0, errs = 0, cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Bench-side f-function: f = R ^ K[idx], K[i] = 0x11111111*i, or zero
    assign f_out = fsel ? (R_dat ^ (32'h11111111 * {27'd0, round_idx})) : 32'd0;

    feistel_round_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .decrypt(decrypt),
        .L_init(L_init), .R_init(R_init), .f_out(f_out), .L_dat(L_dat), .R_dat(R_dat),
        .round_idx(round_idx), .round_en(round_en), .out_valid(out_valid),
        .out_ready(out_ready), .blk_out(blk_out)
    );

    feistel_round_seq #(.HALF_W(16), .ROUNDS(3), .CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .decrypt(s_dec),
        .L_init(s_L), .R_init(s_R), .f_out(16'd0), .L_dat(s_L_dat), .R_dat(s_R_dat),
        .round_idx(s_round_idx), .round_en(s_round_en), .out_valid(s_out_valid),
        .out_ready(1'b1), .blk_out(s_blk)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] l0, input logic [31:0] r0,
                                          input logic dec, input logic fs);
        logic [31:0] l = l0, r = r0, t, k;
        for (int i = 0; i < 16; i++) begin
            k = 32'h11111111 * (dec ? 32'(15 - i) : 32'(i));
            t = r;
            r = l ^ (fs ? (r ^ k) : 32'd0);
            l = t;
        end
        return {r, l};
    endfunction

    // Offers one block, follows it through RUN and DONE; entered and left on a negedge
    task automatic run_block(input logic [31:0] l, input logic [31:0] r, input logic dec,
                             input logic fs, input int stall,
                             output logic [63:0] got, output int acc);
        int n = 0;
        logic [63:0] exp = model(l, r, dec, fs);
        fsel = fs;
        out_ready = (stall == 0);
        in_valid = 1'b1; L_init = l; R_init = r; decrypt = dec;
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        chk("accept_wait", 64'(n < 100), 64'd1);
        @(negedge clk);
        in_valid = 1'b0; decrypt = ~dec; acc = cyc;
        n = 0;
        while (!out_valid && n < 100) begin
            if (n < 16)
                chk("round_ctl", 64'({round_en, in_ready, round_idx}),
                    64'({1'b1, 1'b0, dec ? 5'(15 - n) : 5'(n)}));
            n++;
            @(negedge clk);
        end
        chk("latency", 64'(n), 64'd16);
        chk("blk_out", blk_out, exp);
        chk("done_ready", 64'({in_ready, round_en}), 64'd0);
        got = blk_out;
        for (int s = 0; s < stall; s++) begin
            in_valid = (s == 3);
            L_init = 32'hDEADBEEF;
            @(negedge clk);
            chk("stall_hold", 64'({out_valid, in_ready, blk_out == got}), 64'b101);
        end
        if (stall > 0) begin
            out_ready = 1'b1;
            @(negedge clk);
            chk("stall_release", 64'({in_ready, out_valid, round_en}), 64'b100);
        end
    endtask

    initial begin
        logic [63:0] got, enc;
        int acc, prev, n;
        logic bad;
        repeat (2) @(negedge clk);
        chk("reset_state", 64'({in_ready, out_valid, round_en, round_idx}), 64'b1000_0000);
        chk("reset_blk", blk_out, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run_block(32'h01234567, 32'h89ABCDEF, 1'b0, 1'b0, 0, got, acc);
        chk("identity_enc", got, 64'h89ABCDEF_01234567);
        @(negedge clk);

        run_block(32'h01234567, 32'h89ABCDEF, 1'b0, 1'b1, 0, enc, acc);
        @(negedge clk);
        run_block(enc[63:32], enc[31:0], 1'b1, 1'b1, 10, got, acc);
        chk("decrypt_recover", got, 64'h01234567_89ABCDEF);

        run_block(32'h01234567, 32'h89ABCDEF, 1'b1, 1'b1, 0, got, acc);
        @(negedge clk);

        // Reset during round 7 must discard the block
        fsel = 1'b1; in_valid = 1'b1; L_init = $urandom; R_init = $urandom; decrypt = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        chk("mid_round_idx", 64'({round_en, round_idx}), 64'({1'b1, 5'd7}));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_reset", {in_ready, round_en, out_valid, round_idx, L_dat, R_dat[23:0]},
            {1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 24'd0});
        chk("mid_reset_r", 64'(R_dat), 64'd0);
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bad = bad | out_valid;
            @(negedge clk);
        end
        chk("no_out_after_reset", 64'(bad), 64'd0);
        run_block(32'hCAFEF00D, 32'h13579BDF, 1'b0, 1'b1, 0, got, acc);
        @(negedge clk);

        // Randomized back-to-back traffic with out_ready held high
        prev = -1;
        for (int b = 0; b < 8; b++) begin
            run_block($urandom, $urandom, 1'($urandom), 1'($urandom), 0, got, acc);
            if (prev >= 0) chk("issue_interval", 64'(acc - prev), 64'd18);
            prev = acc;
        end
        @(negedge clk);

        // Three-round, 16-bit instance in decrypt order
        s_in_valid = 1'b1; s_dec = 1'b1; s_L = 16'h1234; s_R = 16'hABCD;
        chk("small_ready", 64'(s_in_ready), 64'd1);
        @(negedge clk);
        s_in_valid = 1'b0; s_dec = 1'b0;
        n = 0;
        while (!s_out_valid && n < 20) begin
            if (n < 3) chk("small_idx", 64'({s_round_en, s_round_idx}), 64'({1'b1, 2'(2 - n)}));
            n++;
            @(negedge clk);
        end
        chk("small_latency", 64'(n), 64'd3);
        chk("small_blk", 64'(s_blk), 64'h1234ABCD);
        @(negedge clk);
        chk("small_idle", 64'({s_in_ready, s_out_valid}), 64'b10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
